estagio_busca: RTL

//  Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the

---
 rtl/estagio_busca.sv | 112 +++++++++++
 1 files changed

// File: rtl/estagio_busca.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register.
// Optional MISALIGN_TRAP_EN: trap misaligned redirect targets.
module estagio_busca #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        desvio,
   input  logic [31:0] alvo_desvio,
   output logic [31:0] pc_addr,
   input  logic [31:0] instrucao_in,
   output logic [31:0] if_id_instrucao,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valido
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        excecao_alinh
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic        valido_q, valido_d;
   logic [31:0] pc_mais4;
   logic [31:0] alvo;
   logic        exc_d;

   assign pc_mais4 = pc_q + 32'd4;

   // Redirect target; misaligned targets divert to the trap vector.
   always_comb begin
      alvo  = alvo_desvio;
      exc_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (desvio && (alvo_desvio[1:0] != 2'b00)) begin
         alvo  = TRAP_VECTOR;
         exc_d = 1'b1;
      end
`endif
   end

   // Next-state selection: desvio > flush > stall > advance.
   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      ipc4_d   = ipc4_q;
      valido_d = valido_q;
      if (desvio || flush) begin
         instr_d  = NOP_WORD;
         ipc_d    = 32'd0;
         ipc4_d   = 32'd0;
         valido_d = 1'b0;
         if (desvio)
            pc_d = alvo;
         else if (!stall)
            pc_d = pc_mais4;
      end else if (!stall) begin
         pc_d     = pc_mais4;
         instr_d  = instrucao_in;
         ipc_d    = pc_q;
         ipc4_d   = pc_mais4;
         valido_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         instr_q  <= NOP_WORD;
         ipc_q    <= 32'd0;
         ipc4_q   <= 32'd0;
         valido_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         ipc4_q   <= ipc4_d;
         valido_q <= valido_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic exc_q;

   // One-cycle misalignment pulse.
   always_ff @(posedge clk) begin
      if (reset) exc_q <= 1'b0;
      else       exc_q <= exc_d;
   end

   assign excecao_alinh = exc_q;
`else
   logic exc_unused;
   assign exc_unused = exc_d;
`endif

   assign pc_addr         = pc_q;
   assign if_id_instrucao = instr_q;
   assign if_id_pc        = ipc_q;
   assign if_id_pc4       = ipc4_q;
   assign if_id_valido    = valido_q;

endmodule
